// File: rtl/tmds_channel_decoder.sv
// tmds_channel_decoder: word-aligns one raw TMDS channel by hunting control tokens and decodes data/control.
// Rev 1.0

`default_nettype none

module tmds_channel_decoder #(
  parameter int SEARCH_WINDOW = 2048,
  parameter int LOCK_TOKENS   = 16
) (
  input  logic       vga_clk,
  input  logic       sys_rst,
  input  logic [9:0] din,
  output logic [7:0] dout,
  output logic       de,
  output logic       c0,
  output logic       c1,
  output logic       locked,
  output logic [3:0] offset
);

  localparam int WD_W  = $clog2(SEARCH_WINDOW) + 1;
  localparam int RUN_W = $clog2(LOCK_TOKENS + 1);
  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(SEARCH_WINDOW - 1);
  localparam logic [WD_W-1:0]  WD_MAX   = WD_W'(SEARCH_WINDOW);
  localparam logic [RUN_W-1:0] RUN_LOCK = RUN_W'(LOCK_TOKENS);

  typedef enum logic [1:0] {
    ST_SEARCH  = 2'd0,
    ST_CONFIRM = 2'd1,
    ST_LOCKED  = 2'd2
  } state_t;

  state_t           state, state_n;
  logic [9:0]       prev_q;
  logic [9:0]       aligned_q;
  logic [WD_W-1:0]  wd_q;
  logic [RUN_W-1:0] run_q;

  logic [19:0]      window;
  logic [19:0]      shifted;
  logic [9:0]       aligned_d;
  logic             tok_d;
  logic [1:0]       tok_d_val;
  logic             tok_q;
  logic [1:0]       tok_q_val;
  logic [7:0]       decoded;
  logic [7:0]       dbits;
  logic [RUN_W-1:0] run_n;
  logic             expire;
  logic             slip;
  logic             locked_n;

  // Returns {is_token, c1, c0}
  function automatic logic [2:0] token_of(input logic [9:0] q);
    logic [2:0] r;
    case (q)
      10'h354: r = 3'b1_00;
      10'h0AB: r = 3'b1_01;
      10'h154: r = 3'b1_10;
      10'h2AB: r = 3'b1_11;
      default: r = 3'b0_00;
    endcase
    return r;
  endfunction

  always_comb begin
    window    = {din, prev_q};
    shifted   = window >> offset;
    aligned_d = shifted[9:0];
    {tok_d, tok_d_val} = token_of(aligned_d);
    {tok_q, tok_q_val} = token_of(aligned_q);
  end

  always_comb begin
    dbits      = aligned_q[9] ? ~aligned_q[7:0] : aligned_q[7:0];
    decoded    = 8'h00;
    decoded[0] = dbits[0];
    for (int i = 1; i < 8; i++) begin
      decoded[i] = aligned_q[8] ? (dbits[i] ^ dbits[i-1]) : ~(dbits[i] ^ dbits[i-1]);
    end
  end

  // Control flow follows the word entering the alignment register, so a token always beats expiry.
  always_comb begin
    run_n    = tok_d ? ((run_q == RUN_LOCK) ? run_q : run_q + 1'b1) : '0;
    expire   = !tok_d && (wd_q >= WD_LAST);
    state_n  = state;
    slip     = 1'b0;
    case (state)
      ST_SEARCH: begin
        if (tok_d) begin
          state_n = ST_CONFIRM;
        end else if (expire) begin
          slip = 1'b1;
        end
      end
      ST_CONFIRM: begin
        if (run_n == RUN_LOCK) begin
          state_n = ST_LOCKED;
        end else if (expire) begin
          slip    = 1'b1;
          state_n = ST_SEARCH;
        end
      end
      ST_LOCKED: begin
        if (expire) begin
          slip    = 1'b1;
          state_n = ST_SEARCH;
        end
      end
      default: state_n = ST_SEARCH;
    endcase
    locked_n = (state_n == ST_LOCKED);
  end

  always_ff @(posedge vga_clk) begin
    if (sys_rst) begin
      state <= ST_SEARCH;
    end else begin
      state <= state_n;
    end
  end

  always_ff @(posedge vga_clk) begin
    if (sys_rst) begin
      prev_q    <= '0;
      aligned_q <= '0;
      wd_q      <= '0;
      run_q     <= '0;
      offset    <= '0;
      locked    <= 1'b0;
    end else begin
      prev_q    <= din;
      aligned_q <= aligned_d;
      run_q     <= run_n;
      locked    <= locked_n;
      if (tok_d || slip) begin
        wd_q <= '0;
      end else if (wd_q != WD_MAX) begin
        wd_q <= wd_q + 1'b1;
      end
      if (slip) begin
        offset <= (offset == 4'd9) ? 4'd0 : offset + 4'd1;
      end
    end
  end

  always_ff @(posedge vga_clk) begin
    if (sys_rst || !locked_n) begin
      dout <= '0;
      de   <= 1'b0;
      c0   <= 1'b0;
      c1   <= 1'b0;
    end else if (tok_q) begin
      dout <= '0;
      de   <= 1'b0;
      c0   <= tok_q_val[0];
      c1   <= tok_q_val[1];
    end else begin
      dout <= decoded;
      de   <= 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_tmds_channel_decoder.sv
// tb_tmds_channel_decoder: directed checks of alignment, lock, decode, slip and wrap.
// Rev 1.0

`default_nettype none

module tb_tmds_channel_decoder;

  localparam int SW = 256;
  localparam int LT = 16;

  logic       clk;
  logic       rst;
  logic [9:0] din;
  logic [7:0] dout;
  logic       de;
  logic       c0;
  logic       c1;
  logic       locked;
  logic [3:0] offset;

  int total;
  int bad;
  int rot;
  int sidx;
  logic [9:0] last_w;

  tmds_channel_decoder #(
    .SEARCH_WINDOW(SW),
    .LOCK_TOKENS  (LT)
  ) dut (
    .vga_clk(clk),
    .sys_rst(rst),
    .din    (din),
    .dout   (dout),
    .de     (de),
    .c0     (c0),
    .c1     (c1),
    .locked (locked),
    .offset (offset)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives one word of the serial stream, rotated by rot bits, then steps one edge.
  task automatic send(input logic [9:0] w);
    logic [19:0] pair;
    logic [19:0] sh;
    pair   = {w, last_w};
    sh     = pair >> (10 - rot);
    din    = sh[9:0];
    last_w = w;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [9:0] stream_word(input int i);
    return ((i % 120) < 20) ? 10'h354 : 10'h100;
  endfunction

  task automatic send_stream();
    send(stream_word(sidx));
    sidx++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    din = 10'h2AB;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    total++; if (locked !== 1'b0) begin bad++; $display("FAIL reset_locked got=%0b want=0", locked); end
    total++; if (offset !== 4'd0) begin bad++; $display("FAIL reset_offset got=%0d want=0", offset); end
    total++; if (de !== 1'b0) begin bad++; $display("FAIL reset_de got=%0b want=0", de); end
    total++; if (dout !== 8'h00) begin bad++; $display("FAIL reset_dout got=%h want=00", dout); end
    total++; if ({c1, c0} !== 2'b00) begin bad++; $display("FAIL reset_c got=%b want=00", {c1, c0}); end
    rst = 1'b0;
  endtask

  task automatic test_aligned_lock();
    rot = 0; sidx = 0; last_w = '0;
    for (int i = 0; i < 16; i++) send_stream();
    total++; if (locked !== 1'b0) begin bad++; $display("FAIL lock_early got=%0b want=0", locked); end
    send_stream();
    total++; if (locked !== 1'b1) begin bad++; $display("FAIL lock_on_time got=%0b want=1", locked); end
    total++; if (offset !== 4'd0) begin bad++; $display("FAIL lock_offset got=%0d want=0", offset); end
    while (sidx < 26) send_stream();
    total++; if ({de, dout, c1, c0} !== {1'b1, 8'h00, 2'b00}) begin
      bad++; $display("FAIL blank_data got de=%b dout=%h c=%b want de=1 dout=00 c=00", de, dout, {c1, c0});
    end
    while (sidx < 126) send_stream();
    total++; if ({de, c1, c0} !== 3'b0_00) begin
      bad++; $display("FAIL blank_token got de=%b c=%b want de=0 c=00", de, {c1, c0});
    end
  endtask

  task automatic test_decode();
    repeat (3) send(10'h354);
    send(10'h1FF);
    send(10'h354);
    total++; if (de !== 1'b0) begin bad++; $display("FAIL latency_early got de=%b want 0", de); end
    send(10'h354);
    total++; if ({de, dout} !== {1'b1, 8'h01}) begin
      bad++; $display("FAIL dec_1ff got de=%b dout=%h want de=1 dout=01", de, dout);
    end
    send(10'h2AB); send(10'h100); send(10'h100);
    total++; if ({de, c1, c0} !== 3'b0_11) begin
      bad++; $display("FAIL tok_2ab got de=%b c=%b want de=0 c=11", de, {c1, c0});
    end
    send(10'h100);
    total++; if ({de, dout, c1, c0} !== {1'b1, 8'h00, 2'b11}) begin
      bad++; $display("FAIL hold_11 got de=%b dout=%h c=%b want de=1 dout=00 c=11", de, dout, {c1, c0});
    end
    send(10'h0AB); send(10'h3F0); send(10'h354);
    total++; if ({de, c1, c0} !== 3'b0_01) begin
      bad++; $display("FAIL tok_0ab got de=%b c=%b want de=0 c=01", de, {c1, c0});
    end
    send(10'h354);
    total++; if ({de, dout, c1, c0} !== {1'b1, 8'h11, 2'b01}) begin
      bad++; $display("FAIL dec_3f0 got de=%b dout=%h c=%b want de=1 dout=11 c=01", de, dout, {c1, c0});
    end
    send(10'h354);
    total++; if ({c1, c0} !== 2'b00) begin bad++; $display("FAIL tok_354 got c=%b want 00", {c1, c0}); end
    send(10'h000); send(10'h354); send(10'h354);
    total++; if ({de, dout} !== {1'b1, 8'hFE}) begin
      bad++; $display("FAIL dec_000 got de=%b dout=%h want de=1 dout=fe", de, dout);
    end
  endtask

  task automatic test_bit_slip();
    int prev_off;
    rst = 1'b1;
    send(10'h354);
    rst = 1'b0;
    total++; if ({locked, offset, de, dout, c1, c0} !== 16'h0) begin
      bad++; $display("FAIL relock_reset got locked=%b off=%0d de=%b dout=%h c=%b want all 0",
                      locked, offset, de, dout, {c1, c0});
    end
    rot = 3; sidx = 0; last_w = '0;
    prev_off = 0;
    for (int i = 0; i < 5 * SW && !locked; i++) begin
      send_stream();
      if (int'(offset) != prev_off) begin
        total++; if (int'(offset) != prev_off + 1) begin
          bad++; $display("FAIL slip_step got=%0d want=%0d", offset, prev_off + 1);
        end
        prev_off = int'(offset);
      end
    end
    total++; if ({locked, offset} !== {1'b1, 4'd3}) begin
      bad++; $display("FAIL slip_lock got locked=%b off=%0d want locked=1 off=3", locked, offset);
    end
    while ((sidx % 120) != 10) send_stream();
    total++; if ({de, c1, c0} !== 3'b0_00) begin
      bad++; $display("FAIL slip_blank got de=%b c=%b want de=0 c=00", de, {c1, c0});
    end
    while ((sidx % 120) != 60) send_stream();
    total++; if ({de, dout} !== {1'b1, 8'h00}) begin
      bad++; $display("FAIL slip_data got de=%b dout=%h want de=1 dout=00", de, dout);
    end
  endtask

  task automatic test_loss_of_lock();
    send(10'h354);
    for (int i = 0; i < SW; i++) send(10'h100);
    total++; if (locked !== 1'b1) begin bad++; $display("FAIL loss_early got=%b want=1", locked); end
    send(10'h100);
    total++; if ({locked, de, offset} !== {1'b0, 1'b0, 4'd4}) begin
      bad++; $display("FAIL loss got locked=%b de=%b off=%0d want locked=0 de=0 off=4", locked, de, offset);
    end
    rot = 4; sidx = 0;
    for (int i = 0; i < 3 * SW && !locked; i++) send_stream();
    total++; if ({locked, offset} !== {1'b1, 4'd4}) begin
      bad++; $display("FAIL reacquire got locked=%b off=%0d want locked=1 off=4", locked, offset);
    end
  endtask

  task automatic test_wrap();
    int prev_off;
    bit saw7;
    bit saw8;
    rot = 9; sidx = 0;
    prev_off = 4; saw7 = 0; saw8 = 0;
    for (int i = 0; i < 8 * SW && !(locked && offset == 4'd9); i++) begin
      send_stream();
      if (offset == 4'd7) saw7 = 1;
      if (offset == 4'd8) saw8 = 1;
      if (int'(offset) != prev_off) begin
        total++; if (int'(offset) != prev_off + 1) begin
          bad++; $display("FAIL wrap_step got=%0d want=%0d", offset, prev_off + 1);
        end
        prev_off = int'(offset);
      end
    end
    total++; if ({locked, offset, saw7, saw8} !== {1'b1, 4'd9, 1'b1, 1'b1}) begin
      bad++; $display("FAIL wrap_lock got locked=%b off=%0d saw7=%b saw8=%b want 1 9 1 1",
                      locked, offset, saw7, saw8);
    end
    for (int i = 0; i < SW + 5; i++) send(10'h100);
    total++; if ({locked, offset} !== {1'b0, 4'd0}) begin
      bad++; $display("FAIL wrap_zero got locked=%b off=%0d want locked=0 off=0", locked, offset);
    end
    for (int i = 0; i < SW; i++) send(10'h100);
    total++; if ({locked, offset} !== {1'b0, 4'd1}) begin
      bad++; $display("FAIL notoken_slip got locked=%b off=%0d want locked=0 off=1", locked, offset);
    end
  endtask

  initial begin
    total = 0; bad = 0; rot = 0; sidx = 0; last_w = '0;
    rst = 1'b1; din = '0;
    test_reset();
    test_aligned_lock();
    test_decode();
    test_bit_slip();
    test_loss_of_lock();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
